// File: rtl/bus_pkg.sv
// Shared bus definitions: address width, broadcast address and destination extraction.
package bus_pkg;

   localparam int ADDR_W    = 8;
   localparam int PKT_MAX_W = 64;

   typedef logic [ADDR_W-1:0]    addr_t;
   typedef logic [PKT_MAX_W-1:0] pkt_t;

   localparam addr_t BCAST_ADDR = 8'hFF;

   // Callers left-justify their packet into pkt_t so the destination is always the top byte.
   function automatic addr_t get_dest(input pkt_t pkt);
      return pkt[PKT_MAX_W-1 -: ADDR_W];
   endfunction

endpackage

// File: rtl/bus_rx_fifo_mem.sv
// FIFO storage: depth x width register array, one synchronous write port, one asynchronous read port.
module bus_rx_fifo_mem #(
   parameter int width = 16,
   parameter int depth = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(depth)-1:0] waddr,
   input  logic [width-1:0]         wdata,
   input  logic [$clog2(depth)-1:0] raddr,
   output logic [width-1:0]         rdata
);

   logic [width-1:0] mem [depth];

   // NOTE: storage is deliberately not reset; stale entries are masked by count in the parent.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bus_rx_fifo.sv
// Receive-side endpoint FIFO: show-ahead buffer with overflow/underflow flags and misroute counting.
module bus_rx_fifo
   import bus_pkg::*;
#(
   parameter int          width = 16,
   parameter int          depth = 8,
   parameter int unsigned id    = 0,
   parameter addr_t       bcast = BCAST_ADDR
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [width-1:0]         D_push,
   input  logic                     pop,
   output logic [width-1:0]         D_pop,
   output logic                     pndng,
   output logic                     full,
   output logic [$clog2(depth):0]   count,
   output logic                     overflow,
   output logic                     underflow,
   output logic [15:0]              misroute_cnt
);

   localparam int PTR_W = $clog2(depth);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [width-1:0] rd_data;
   logic             push_ok, pop_ok, misrouted;
   addr_t            dest;

   bus_rx_fifo_mem #(.width(width), .depth(depth)) u_mem (
      .clk   (clk),
      .we    (push_ok),
      .waddr (wr_ptr),
      .wdata (D_push),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   assign pndng = (count != '0);
   assign full  = (count == CNT_W'(depth));
   assign D_pop = pndng ? rd_data : '0;

   always_comb begin
      push_ok   = push && (!full || pop);
      pop_ok    = pop && pndng;
      dest      = get_dest(pkt_t'(D_push) << (PKT_MAX_W - width));
      misrouted = (dest != addr_t'(id)) && (dest != bcast);
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values of the others.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
         misroute_cnt <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && full && !pop) overflow  <= 1'b1;
         if (pop && !pndng)        underflow <= 1'b1;
         if (push_ok && misrouted && misroute_cnt != 16'hFFFF)
            misroute_cnt <= misroute_cnt + 1'b1;
      end
   end

endmodule

// File: doc/bus_rx_fifo.md
# bus_rx_fifo

Receive-side endpoint FIFO for the `bs_gnrtr_n_rbtr` bus driver. One instance sits on each of the `drvrs` output ports and sinks the `push`/`D_push` traffic the bus emits toward device `id`. It buffers accepted packets in show-ahead order for the monitor, which drains them through a `pndng`/`pop`/`D_pop` port identical to the transmit side. It also flags overflow, underflow, and packets whose destination field does not address this device.

## Interface
Parameters:
- `width`, 16, packet width in bits; must be ≥ 9.
- `depth`, 8, FIFO entries; power of two, ≥ 2.
- `id`, 0, this device's address, 0..254.
- `bcast`, 8'hFF, broadcast address; taken from the shared package.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `push`  in  1  bus writes `D_push` this cycle.
- `D_push`  in  `width`  packet from bus; `[width-1:width-8]` is the destination address.
- `pop`  in  1  monitor consumes the head entry.
- `D_pop`  out  `width`  head entry (show-ahead); 0 when empty.
- `pndng`  out  1  FIFO non-empty.
- `full`  out  1  count == `depth`.
- `count`  out  `$clog2(depth)+1`  occupancy.
- `overflow`  out  1  sticky: a push was dropped.
- `underflow`  out  1  sticky: a pop was issued while empty.
- `misroute_cnt`  out  16  saturating count of accepted packets whose destination is neither `id` nor `bcast`.

## Operation
- Storage: circular buffer with `wr_ptr`/`rd_ptr` of `$clog2(depth)` bits, wrapping at `depth`. `count` is held separately.
- Push accepted when `push && (!full || pop)`. The entry is written at `wr_ptr` and `wr_ptr` advances.
- Push while full without pop: packet dropped, `overflow` set, pointers unchanged.
- Pop accepted when `pop && pndng`; `rd_ptr` advances.
- Pop while empty: ignored, `underflow` set.
- Simultaneous push and pop:
  - When non-empty, both are accepted and `count` is unchanged.
  - When empty, the pop is ignored and flags `underflow`; the push is accepted and `count` becomes 1.
  - When full, both are accepted and `full` stays 1.
- Destination check applies to every accepted push. If `D_push[width-1:width-8] != id` and `!= bcast`, `misroute_cnt` increments, saturating at 16'hFFFF. The packet is stored regardless.
- Dropped (overflow) packets are not checked for destination.
- `overflow` and `underflow` clear only on `reset`.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk` deassert handled upstream) drives:
  - `count` = 0, `pndng` = 0, `full` = 0
  - `D_pop` = 0, `overflow` = 0, `underflow` = 0, `misroute_cnt` = 0
  - both pointers = 0
- Reset mid-operation discards all stored entries immediately.
- Push at rising edge N: `pndng`, `count`, and `D_pop` reflect the new entry from edge N onward, i.e. valid in cycle N+1. Write-to-read latency is 1 cycle.
- `D_pop`, `pndng`, `full`, and `count` are registered outputs or decoded from registered state; no combinational path from `push`/`pop` to any output.
- Pop at edge N: `D_pop` shows the next entry in cycle N+1, or 0 if the FIFO became empty.
- `misroute_cnt` updates in the same cycle as the corresponding `count` change.

## Structure
- Package `bus_pkg` holds:
  - `BCAST_ADDR` = 8'hFF and `ADDR_W` = 8.
  - Function `get_dest(pkt)` that returns the top `ADDR_W` bits.
  - `typedef logic [ADDR_W-1:0] addr_t`.
- Sub-module `bus_rx_fifo_mem`: `depth` × `width` register array with one synchronous write port and one asynchronous read port. Its read output feeds the `D_pop` mux, which forces 0 when empty.
- Top level holds the pointers, count, flags, and destination checker.

## Test plan
- Reset then idle: all outputs 0. Pop with `id`=3 → `underflow`=1, `count`=0.
- Push 16'h0301, 16'h0302, 16'h0303 on consecutive cycles → `count`=3 and `D_pop`=16'h0301. Then three pops yield 0302, 0303, then 0 with `pndng`=0.
- Fill `depth`=8, then push 16'h03AA → `overflow`=1, `count`=8, and 16'h03AA is never popped.
- Full FIFO with simultaneous push 16'h03BB and pop → `count` stays 8 and `full`=1; after 8 further pops the last value is 16'h03BB. Wrap-around covered.
- With `id`=3, push 16'h0510, 16'hFF11, 16'h0312 → `misroute_cnt`=1 and all three are stored.
- Assert `reset` mid-burst with 5 entries stored → outputs return to reset values asynchronously, before the next `clk` edge.
